// File: rtl/poisson_spike_gen.sv
// poisson_spike_gen: N_CH independent pseudo-random (Bernoulli-per-cycle) spike
// sources. Each channel owns a Fibonacci LFSR and a programmable rate threshold.
// When a channel is ready and (lfsr < rate), it emits a PULSE_W-cycle pulse,
// followed by REFRACT dead cycles, and bumps a saturating spike counter.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous active-low reset
//   run        global enable: advances LFSRs, allows trials
//   chan_en    per-channel trial enable
//   spk_clr    abort all pulses / refractory periods (no trial that cycle)
//   cfg_wr     rate write strobe; cfg_ch selects channel, cfg_rate is the value
//   cnt_clr    clear all spike counters
//   spike_out  registered spike pulses, one bit per channel
//   spike_cnt  per-channel saturating counts, channel i at [i*CNT_W +: CNT_W]

module poisson_chan #(
  parameter int                 RATE_W       = 16,
  parameter int                 PULSE_W      = 2,
  parameter int                 REFRACT      = 0,
  parameter int                 CNT_W        = 12,
  parameter logic [RATE_W-1:0]  SEED_I       = '1,
  parameter logic [RATE_W-1:0]  RATE_RST     = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              en,
  input  logic              spk_clr,
  input  logic              cfg_hit,
  input  logic [RATE_W-1:0] cfg_rate,
  input  logic              cnt_clr,
  output logic              spike,
  output logic [CNT_W-1:0]  cnt
);

  // Maximal-length tap exponents, bit (t-1) set for each term x^t.
  function automatic logic [31:0] tap_exp(input int w);
    case (w)
      3:  return 32'h6;
      4:  return 32'hC;
      5:  return 32'h14;
      6:  return 32'h30;
      7:  return 32'h60;
      8:  return 32'hB8;
      9:  return 32'h110;
      10: return 32'h240;
      11: return 32'h500;
      12: return 32'h829;
      13: return 32'h100D;
      14: return 32'h2015;
      15: return 32'h6000;
      16: return 32'hB400;
      17: return 32'h12000;
      18: return 32'h20400;
      19: return 32'h40023;
      20: return 32'h90000;
      24: return 32'hE10000;
      32: return 32'h80200003;
      default: return 32'h6;
    endcase
  endfunction

  // Right-shifting register: tap x^t is read from bit (RATE_W - t).
  function automatic logic [RATE_W-1:0] fb_mask(input logic [31:0] ex);
    logic [RATE_W-1:0] m;
    m = '0;
    for (int k = 0; k < RATE_W; k++) m[k] = ex[RATE_W-1-k];
    return m;
  endfunction

  localparam logic [RATE_W-1:0] FB_MASK  = fb_mask(tap_exp(RATE_W));
  localparam logic [7:0]        PW_M1    = 8'(PULSE_W - 1);
  localparam logic [7:0]        RF_M1    = (REFRACT > 0) ? 8'(REFRACT - 1) : 8'd0;
  localparam bit                NO_REFR  = (REFRACT == 0);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE, PULSE, REFR} state_t;

  state_t            state;
  logic [7:0]        tcnt;
  logic [RATE_W-1:0] lfsr, rate, lfsr_nxt;
  logic              ready, fire;

  assign lfsr_nxt = {^(lfsr & FB_MASK), lfsr[RATE_W-1:1]};

  // The last cycle of a pulse (no refractory) or of the refractory period
  // already counts as idle, so a new pulse can follow with no gap.
  assign ready = (state == IDLE)
               | (state == PULSE && tcnt == 8'd0 && NO_REFR)
               | (state == REFR  && tcnt == 8'd0);
  assign fire  = ready & run & en & ~spk_clr & (lfsr < rate);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      tcnt  <= '0;
      spike <= 1'b0;
      cnt   <= '0;
      rate  <= RATE_RST;
      lfsr  <= SEED_I;
    end else begin
      if (run)     lfsr <= lfsr_nxt;
      if (cfg_hit) rate <= cfg_rate;   // trial this edge still sees old rate

      if (cnt_clr)                       cnt <= '0;
      else if (fire && cnt != CNT_MAX)   cnt <= cnt + CNT_W'(1);

      if (spk_clr) begin
        state <= IDLE;
        spike <= 1'b0;
        tcnt  <= '0;
      end else if (fire) begin
        state <= PULSE;
        spike <= 1'b1;
        tcnt  <= PW_M1;
      end else begin
        case (state)
          IDLE: ;
          PULSE: begin
            if (tcnt == 8'd0) begin
              spike <= 1'b0;
              if (NO_REFR) begin
                state <= IDLE;
              end else begin
                state <= REFR;
                tcnt  <= RF_M1;
              end
            end else begin
              tcnt <= tcnt - 8'd1;
            end
          end
          REFR: begin
            if (tcnt == 8'd0) state <= IDLE;
            else              tcnt  <= tcnt - 8'd1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

module poisson_spike_gen #(
  parameter int          N_CH         = 5,
  parameter int          RATE_W       = 16,
  parameter int          PULSE_W      = 2,
  parameter int          REFRACT      = 0,
  parameter int          CNT_W        = 12,
  parameter logic [31:0] SEED         = 32'h0000ACE1,
  parameter logic [31:0] DEFAULT_RATE = 32'd655
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    run,
  input  logic [N_CH-1:0]         chan_en,
  input  logic                    spk_clr,
  input  logic                    cfg_wr,
  input  logic [7:0]              cfg_ch,
  input  logic [RATE_W-1:0]       cfg_rate,
  input  logic                    cnt_clr,
  output logic [N_CH-1:0]         spike_out,
  output logic [N_CH*CNT_W-1:0]   spike_cnt
);

  logic [N_CH-1:0][CNT_W-1:0] cnt_arr;

  // Packed layout already places channel i at [i*CNT_W +: CNT_W].
  assign spike_cnt = cnt_arr;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    localparam logic [31:0]       SEED_RAW = SEED + 32'(i) * 32'h1F35;
    localparam logic [RATE_W-1:0] SEED_T   = SEED_RAW[RATE_W-1:0];
    localparam logic [RATE_W-1:0] SEED_I   = (SEED_T == '0) ? RATE_W'(1) : SEED_T;

    // Out-of-range cfg_ch matches no channel and is dropped.
    logic cfg_hit;
    assign cfg_hit = cfg_wr && (cfg_ch == 8'(i));

    poisson_chan #(
      .RATE_W   (RATE_W),
      .PULSE_W  (PULSE_W),
      .REFRACT  (REFRACT),
      .CNT_W    (CNT_W),
      .SEED_I   (SEED_I),
      .RATE_RST (DEFAULT_RATE[RATE_W-1:0])
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .run      (run),
      .en       (chan_en[i]),
      .spk_clr  (spk_clr),
      .cfg_hit  (cfg_hit),
      .cfg_rate (cfg_rate),
      .cnt_clr  (cnt_clr),
      .spike    (spike_out[i]),
      .cnt      (cnt_arr[i])
    );
  end

endmodule

// File: tb/tb_poisson_spike_gen.sv
// Scoreboard bench for poisson_spike_gen. Two instances share all inputs:
// dut0 (PULSE_W=2, REFRACT=0, CNT_W=5) and dut1 (PULSE_W=3, REFRACT=3, CNT_W=12).
// The reference model is time-based: a channel firing at edge e is high for the
// outputs after edges e..e+PW-1 and may try again from edge e+PW+RF.

module tb_poisson_spike_gen;

  localparam int N   = 5;
  localparam int CW0 = 5;
  localparam int CW1 = 12;
  localparam int PW0 = 2, RF0 = 0;
  localparam int PW1 = 3, RF1 = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b0, run = 1'b0, spk_clr = 1'b0, cfg_wr = 1'b0, cnt_clr = 1'b0;
  logic [N-1:0]      chan_en = '0;
  logic [7:0]        cfg_ch = '0;
  logic [15:0]       cfg_rate = '0;
  logic [N-1:0]      spk0, spk1;
  logic [N*CW0-1:0]  cnt0;
  logic [N*CW1-1:0]  cnt1;

  always #5 clk = ~clk;

  poisson_spike_gen #(.N_CH(N), .PULSE_W(PW0), .REFRACT(RF0), .CNT_W(CW0)) u_dut0 (
    .clk(clk), .reset(reset), .run(run), .chan_en(chan_en), .spk_clr(spk_clr),
    .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_rate(cfg_rate), .cnt_clr(cnt_clr),
    .spike_out(spk0), .spike_cnt(cnt0));

  poisson_spike_gen #(.N_CH(N), .PULSE_W(PW1), .REFRACT(RF1), .CNT_W(CW1)) u_dut1 (
    .clk(clk), .reset(reset), .run(run), .chan_en(chan_en), .spk_clr(spk_clr),
    .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_rate(cfg_rate), .cnt_clr(cnt_clr),
    .spike_out(spk1), .spike_cnt(cnt1));

  typedef struct {
    logic [N-1:0]     s0, s1;
    logic [N*CW0-1:0] c0;
    logic [N*CW1-1:0] c1;
  } exp_t;

  exp_t sb[$];
  int   tests = 0, fails = 0;

  // reference model state
  logic [15:0] m_lfsr[N];
  logic [15:0] m_rate[N];
  longint      free_e[2][N];
  longint      hi_end[2][N];
  int          mcnt[2][N];
  longint      e = 0;

  // x^16+x^14+x^13+x^11+1 on a right-shifting register: term x^t reads bit 16-t
  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    int   taps[4] = '{16, 14, 13, 11};
    logic fb = 1'b0;
    foreach (taps[k]) fb ^= x[16 - taps[k]];
    return {fb, x[15:1]};
  endfunction

  function automatic logic [15:0] seed_of(input int i);
    logic [31:0] s;
    s = 32'hACE1 + 32'(i) * 32'h1F35;
    return (s[15:0] == 16'd0) ? 16'd1 : s[15:0];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s edge~%0d: got %h expected %h", nm, tests / 4, act, exp);
    end
  endtask

  // Drive one cycle of inputs (called just after a negedge) and push the
  // expected outputs seen after the next posedge.
  task automatic cyc(input bit rst, input bit run_i, input logic [N-1:0] en_i,
                     input bit clr_i, input bit wr_i, input logic [7:0] ch_i,
                     input logic [15:0] rate_i, input bit cc_i);
    exp_t x;
    int   pw, rf, cmax;
    bit   fire;
    @(negedge clk);
    reset = rst; run = run_i; chan_en = en_i; spk_clr = clr_i;
    cfg_wr = wr_i; cfg_ch = ch_i; cfg_rate = rate_i; cnt_clr = cc_i;
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        m_lfsr[i] = seed_of(i);
        m_rate[i] = 16'd655;
        for (int d = 0; d < 2; d++) begin
          free_e[d][i] = e + 1; hi_end[d][i] = e; mcnt[d][i] = 0;
        end
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        pw = (d == 0) ? PW0 : PW1;
        rf = (d == 0) ? RF0 : RF1;
        cmax = (d == 0) ? (1 << CW0) - 1 : (1 << CW1) - 1;
        for (int i = 0; i < N; i++) begin
          fire = (e >= free_e[d][i]) && run_i && en_i[i] && !clr_i && (m_lfsr[i] < m_rate[i]);
          if (clr_i) begin
            free_e[d][i] = e + 1; hi_end[d][i] = e;
          end else if (fire) begin
            hi_end[d][i] = e + pw; free_e[d][i] = e + pw + rf;
          end
          if (cc_i) mcnt[d][i] = 0;
          else if (fire && mcnt[d][i] < cmax) mcnt[d][i]++;
        end
      end
      for (int i = 0; i < N; i++) if (run_i) m_lfsr[i] = lfsr_step(m_lfsr[i]);
      if (wr_i && ch_i < 8'(N)) m_rate[ch_i] = rate_i;
    end
    for (int i = 0; i < N; i++) begin
      x.s0[i] = (e < hi_end[0][i]);
      x.s1[i] = (e < hi_end[1][i]);
      x.c0[i*CW0 +: CW0] = CW0'(mcnt[0][i]);
      x.c1[i*CW1 +: CW1] = CW1'(mcnt[1][i]);
    end
    sb.push_back(x);
    e++;
  endtask

  // monitor: outputs are presented every cycle, compared just after the edge
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        chk("spike0", 64'(spk0), 64'(x.s0));
        chk("spike1", 64'(spk1), 64'(x.s1));
        chk("cnt0",   64'(cnt0), 64'(x.c0));
        chk("cnt1",   64'(cnt1), 64'(x.c1));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end

  logic [15:0] rr;
  initial begin
    // reset dominates cfg_wr, spk_clr, cnt_clr
    repeat (3) cyc(0, 1, '1, 1, 1, 8'd3, 16'h1234, 1);
    // default-rate activity
    repeat (60) cyc(1, 1, '1, 0, 0, 8'd0, 16'h0, 0);
    // all rates to FFFF while frozen, then continuous firing and saturation
    for (int i = 0; i < N; i++) cyc(1, 0, '1, 0, 1, 8'(i), 16'hFFFF, 0);
    repeat (90) cyc(1, 1, '1, 0, 0, 8'd0, 16'h0, 0);
    // writes to nonexistent channels
    repeat (4) cyc(1, 1, '1, 0, 1, 8'($urandom_range(5, 255)), 16'($urandom), 0);
    repeat (10) cyc(1, 1, '1, 0, 0, 8'd0, 16'h0, 0);
    cyc(1, 1, '1, 0, 0, 8'd0, 16'h0, 1);   // clear on firing edges
    // rate[2]=0, others half scale
    for (int i = 0; i < N; i++) cyc(1, 1, '1, 0, 1, 8'(i), (i == 2) ? 16'h0 : 16'h8000, 0);
    repeat (600) cyc(1, 1, ($urandom % 4 == 0) ? N'($urandom) : '1,
                     ($urandom % 50) == 0, 0, 8'd0, 16'h0, ($urandom % 200) == 0);
    // freeze mid-activity, then resume
    repeat (100) cyc(1, 0, '1, 0, 0, 8'd0, 16'h0, 0);
    repeat (50)  cyc(1, 1, '1, 0, 0, 8'd0, 16'h0, 0);
    // spk_clr right after a firing edge
    cyc(1, 0, '1, 0, 1, 8'd0, 16'hFFFF, 0);
    repeat (5) begin
      cyc(1, 1, '1, 0, 0, 8'd0, 16'h0, 0);
      cyc(1, 1, '1, 1, 0, 8'd0, 16'h0, 0);
    end
    // fully random traffic
    repeat (1500) begin
      case ($urandom % 4)
        0:       rr = 16'h0000;
        1:       rr = 16'hFFFF;
        default: rr = 16'($urandom);
      endcase
      cyc(($urandom % 400) != 0, ($urandom % 8) != 0, N'($urandom), ($urandom % 30) == 0,
          ($urandom % 10) == 0, 8'($urandom_range(0, 7)), rr, ($urandom % 150) == 0);
    end
    // reset in the middle of a pulse
    for (int i = 0; i < N; i++) cyc(1, 0, '1, 0, 1, 8'(i), 16'hFFFF, 0);
    repeat (3) cyc(1, 1, '1, 0, 0, 8'd0, 16'h0, 0);
    cyc(0, 1, '1, 0, 0, 8'd0, 16'h0, 0);
    repeat (20) cyc(1, 1, '1, 0, 0, 8'd0, 16'h0, 0);
    repeat (3) @(negedge clk);
    chk("sb_drain", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
